// File: rtl/mfp_eic_input_filter.sv
// rtl/mfp_eic_input_filter.sv - interrupt line synchronizer and per-channel debounce filter
//
// Conditions raw asynchronous interrupt lines for the EIC core. Each line runs
// through a SYNC_STAGES-deep synchronizer, then a two-state debounce FSM that
// accepts a new level only after DEBOUNCE_LEN consecutive equal synced samples.
// A per-channel bypass takes the synced level directly, for sources that are
// already clean.
//
// Ports:
//   CLK      in   1         clock
//   RESETn   in   1         synchronous reset, active low
//   raw_in   in   CHANNELS  asynchronous interrupt sources
//   bypass   in   CHANNELS  1: output follows the synced input, no debounce
//   signal   out  CHANNELS  conditioned levels to the EIC core (registered)
//   change   out  CHANNELS  one-cycle pulse when signal[i] has just toggled (registered)
//   busy     out  1         some channel is qualifying a change (from state only)

module mfp_eic_input_filter #(
   parameter int                     CHANNELS     = 8,
   parameter int                     SYNC_STAGES  = 2,
   parameter int                     DEBOUNCE_W   = 4,
   parameter int                     DEBOUNCE_LEN = 10,
   parameter logic [CHANNELS-1:0]    IDLE_LEVEL   = '0
) (
   input  logic                CLK,
   input  logic                RESETn,
   input  logic [CHANNELS-1:0] raw_in,
   input  logic [CHANNELS-1:0] bypass,
   output logic [CHANNELS-1:0] signal,
   output logic [CHANNELS-1:0] change,
   output logic                busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CHECK = 1'b1
   } state_t;

   localparam logic [DEBOUNCE_W-1:0] CNT_ONE  = DEBOUNCE_W'(1);
   localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_W'(DEBOUNCE_LEN - 1);

   // Synchronizer chain. Flops reset to IDLE_LEVEL so that low-level-sense
   // channels do not see a false edge coming out of reset.
   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] s_sync;

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= IDLE_LEVEL;
         end
      end else begin
         sync_q[0] <= raw_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign s_sync = sync_q[SYNC_STAGES-1];

   logic [CHANNELS-1:0] check_vec;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_t                state_q;
      logic [DEBOUNCE_W-1:0] cnt_q;
      logic                  sig_q;
      logic                  chg_q;

      always_ff @(posedge CLK) begin
         if (!RESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sig_q   <= IDLE_LEVEL[i];
            chg_q   <= 1'b0;
         end else begin
            chg_q <= 1'b0;
            if (bypass[i]) begin
               // Bypass aborts any check in progress and tracks the synced level.
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               sig_q   <= s_sync[i];
               chg_q   <= (s_sync[i] != sig_q);
            end else begin
               case (state_q)
                  ST_IDLE: begin
                     if (s_sync[i] != sig_q) begin
                        state_q <= ST_CHECK;
                        cnt_q   <= CNT_ONE;
                     end else begin
                        cnt_q   <= '0;
                     end
                  end
                  ST_CHECK: begin
                     if (s_sync[i] == sig_q) begin
                        // Input went back before qualifying: treat as a glitch.
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                     end else if (cnt_q == CNT_LAST) begin
                        sig_q   <= s_sync[i];
                        chg_q   <= 1'b1;
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                     end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                     end
                  end
                  default: begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                  end
               endcase
            end
         end
      end

      assign signal[i]    = sig_q;
      assign change[i]    = chg_q;
      assign check_vec[i] = (state_q == ST_CHECK);
   end

   assign busy = |check_vec;

endmodule

// File: tb/tb_mfp_eic_input_filter.sv
// tb/tb_mfp_eic_input_filter.sv - directed table-driven bench for mfp_eic_input_filter

module tb_mfp_eic_input_filter;

   logic       CLK;
   logic       RESETn;
   logic [7:0] raw_in;
   logic [7:0] bypass;
   logic [7:0] signal_a, change_a;
   logic       busy_a;
   logic [7:0] signal_b, change_b;
   logic       busy_b;

   int total = 0;
   int bad   = 0;

   mfp_eic_input_filter dut_a (
      .CLK    (CLK),
      .RESETn (RESETn),
      .raw_in (raw_in),
      .bypass (bypass),
      .signal (signal_a),
      .change (change_a),
      .busy   (busy_a)
   );

   mfp_eic_input_filter #(.IDLE_LEVEL(8'h01)) dut_b (
      .CLK    (CLK),
      .RESETn (RESETn),
      .raw_in (raw_in),
      .bypass (bypass),
      .signal (signal_b),
      .change (change_b),
      .busy   (busy_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] raw;
      logic [7:0] byp;
      int         cycles;
      logic [7:0] exp_sig;
      logic [7:0] exp_chg;
      logic       exp_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic [7:0] raw, input logic [7:0] byp, input int cycles,
                          input logic [7:0] exp_sig, input logic [7:0] exp_chg, input logic exp_busy);
      vec_t v;
      v.raw = raw; v.byp = byp; v.cycles = cycles;
      v.exp_sig = exp_sig; v.exp_chg = exp_chg; v.exp_busy = exp_busy;
      vecs.push_back(v);
   endtask

   task automatic step(input int n);
      for (int j = 0; j < n; j++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      RESETn = 1'b0;
      raw_in = 8'h00;
      bypass = 8'h00;

      // Reset state on both instances
      step(3);
      check8("rst_sig_a", signal_a, 8'h00);
      check8("rst_chg_a", change_a, 8'h00);
      check8("rst_busy_a", {7'd0, busy_a}, 8'h00);
      check8("rst_sig_b", signal_b, 8'h01);
      check8("rst_chg_b", change_b, 8'h00);
      check8("rst_busy_b", {7'd0, busy_b}, 8'h00);

      // IDLE_LEVEL=1 channel falls SYNC_STAGES+DEBOUNCE_LEN cycles after release
      RESETn = 1'b1;
      step(11);
      check8("idle_b_hold", signal_b, 8'h01);
      step(1);
      check8("idle_b_fall", signal_b, 8'h00);
      check8("idle_b_chg", change_b, 8'h01);
      check8("idle_a_quiet", signal_a, 8'h00);

      // Single rising edge on ch3
      add_vec(8'h08, 8'h00, 2,  8'h00, 8'h00, 1'b0);
      add_vec(8'h08, 8'h00, 1,  8'h00, 8'h00, 1'b1);
      add_vec(8'h08, 8'h00, 8,  8'h00, 8'h00, 1'b1);
      add_vec(8'h08, 8'h00, 1,  8'h08, 8'h08, 1'b0);
      add_vec(8'h08, 8'h00, 1,  8'h08, 8'h00, 1'b0);
      // 9-cycle glitch on ch5 never qualifies
      add_vec(8'h28, 8'h00, 9,  8'h08, 8'h00, 1'b1);
      add_vec(8'h08, 8'h00, 2,  8'h08, 8'h00, 1'b1);
      add_vec(8'h08, 8'h00, 1,  8'h08, 8'h00, 1'b0);
      add_vec(8'h08, 8'h00, 10, 8'h08, 8'h00, 1'b0);
      // ch3 back low, then all eight channels rise together
      add_vec(8'h00, 8'h00, 12, 8'h00, 8'h08, 1'b0);
      add_vec(8'hFF, 8'h00, 11, 8'h00, 8'h00, 1'b1);
      add_vec(8'hFF, 8'h00, 1,  8'hFF, 8'hFF, 1'b0);
      add_vec(8'hFF, 8'h00, 1,  8'hFF, 8'h00, 1'b0);
      add_vec(8'h00, 8'h00, 12, 8'h00, 8'hFF, 1'b0);
      // Bypass on ch2 with a one-cycle raw pulse
      add_vec(8'h04, 8'h04, 1,  8'h00, 8'h00, 1'b0);
      add_vec(8'h00, 8'h04, 1,  8'h00, 8'h00, 1'b0);
      add_vec(8'h00, 8'h04, 1,  8'h04, 8'h04, 1'b0);
      add_vec(8'h00, 8'h04, 1,  8'h00, 8'h04, 1'b0);
      add_vec(8'h00, 8'h04, 1,  8'h00, 8'h00, 1'b0);
      // ch6: bypass asserted mid-check takes s, dropping it causes no toggle
      add_vec(8'h40, 8'h00, 4,  8'h00, 8'h00, 1'b1);
      add_vec(8'h40, 8'h40, 1,  8'h40, 8'h40, 1'b0);
      add_vec(8'h40, 8'h00, 12, 8'h40, 8'h00, 1'b0);
      add_vec(8'h00, 8'h00, 12, 8'h00, 8'h40, 1'b0);

      foreach (vecs[n]) begin
         raw_in = vecs[n].raw;
         bypass = vecs[n].byp;
         step(vecs[n].cycles);
         check8($sformatf("v%0d_sig", n), signal_a, vecs[n].exp_sig);
         check8($sformatf("v%0d_chg", n), change_a, vecs[n].exp_chg);
         check8($sformatf("v%0d_busy", n), {7'd0, busy_a}, {7'd0, vecs[n].exp_busy});
      end

      // Reset at CHECK cycle 5 on ch1 discards the pending change
      raw_in = 8'h02;
      bypass = 8'h00;
      step(7);
      check8("mid_busy", {7'd0, busy_a}, 8'h01);
      RESETn = 1'b0;
      step(1);
      RESETn = 1'b1;
      check8("mid_rst_sig_a", signal_a, 8'h00);
      check8("mid_rst_busy_a", {7'd0, busy_a}, 8'h00);
      check8("mid_rst_sig_b", signal_b, 8'h01);
      step(11);
      check8("requal_hold", signal_a, 8'h00);
      check8("requal_busy", {7'd0, busy_a}, 8'h01);
      step(1);
      check8("requal_sig", signal_a, 8'h02);
      check8("requal_chg", change_a, 8'h02);
      step(1);
      check8("requal_chg_end", change_a, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
